// File: rtl/snoop_pkg.sv
// rtl/snoop_pkg.sv - shared command codes, FSM states and helpers for the snoop bus arbiter
package snoop_pkg;

    localparam logic [2:0] CMD_NOP  = 3'b000;
    localparam logic [2:0] CMD_RD   = 3'b001;
    localparam logic [2:0] CMD_RDX  = 3'b010;
    localparam logic [2:0] CMD_UPGR = 3'b011;
    localparam logic [2:0] CMD_WB   = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BCAST   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_COLLECT = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Reserved codes (101-111) and NOP never win the bus.
    // Commands are zero-extended to 8 bits so any CMD_W up to 8 works.
    function automatic logic is_valid_cmd(input logic [7:0] cmd);
        return (cmd >= 8'(CMD_RD)) && (cmd <= 8'(CMD_WB));
    endfunction

endpackage

// File: rtl/snoop_bus_arbiter_rr_pick4.sv
// rtl/snoop_bus_arbiter_rr_pick4.sv - combinational 4-way round-robin picker
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] onehot,
    output logic [1:0] idx
);

    logic       found;
    logic [1:0] cand;

    // Scan from ptr upward with wrap; the first set request wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (!found && req[cand]) begin
                found        = 1'b1;
                onehot[cand] = 1'b1;
                idx          = cand;
            end
        end
    end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// rtl/snoop_bus_arbiter.sv - snoop bus arbiter: pick, broadcast, wait, collect owned flags
module snoop_bus_arbiter
    import snoop_pkg::*;
#(
    parameter int ADDR_W    = 24,
    parameter int CMD_W     = 3,
    parameter int SNOOP_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req,
    input  logic [3:0]        pri,
    input  logic [CMD_W-1:0]  sp_in_0,
    input  logic [CMD_W-1:0]  sp_in_1,
    input  logic [CMD_W-1:0]  sp_in_2,
    input  logic [CMD_W-1:0]  sp_in_3,
    input  logic [ADDR_W-1:0] addr_sp_0,
    input  logic [ADDR_W-1:0] addr_sp_1,
    input  logic [ADDR_W-1:0] addr_sp_2,
    input  logic [ADDR_W-1:0] addr_sp_3,
    input  logic              owned_0,
    input  logic              owned_1,
    input  logic              owned_2,
    input  logic              owned_3,
    output logic [CMD_W-1:0]  sp_out,
    output logic [ADDR_W-1:0] addr_sp_out,
    output logic              sp_valid,
    output logic [3:0]        grant,
    output logic [3:0]        done,
    output logic [1:0]        share_num,
    output logic              owned_any
);

    localparam int CNT_W = $clog2(SNOOP_LAT) + 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(SNOOP_LAT > 1 ? SNOOP_LAT - 2 : 0);

    logic [CMD_W-1:0]  cmd_arr  [4];
    logic [ADDR_W-1:0] addr_arr [4];
    logic [3:0]        owned_vec;

    assign cmd_arr[0]  = sp_in_0;
    assign cmd_arr[1]  = sp_in_1;
    assign cmd_arr[2]  = sp_in_2;
    assign cmd_arr[3]  = sp_in_3;
    assign addr_arr[0] = addr_sp_0;
    assign addr_arr[1] = addr_sp_1;
    assign addr_arr[2] = addr_sp_2;
    assign addr_arr[3] = addr_sp_3;
    assign owned_vec   = {owned_3, owned_2, owned_1, owned_0};

    state_t            state_q, state_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [1:0]        win_idx_q, win_idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CMD_W-1:0]  sp_out_q, sp_out_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              sp_valid_q, sp_valid_d;
    logic [3:0]        grant_q, grant_d;
    logic [3:0]        done_q, done_d;
    logic [1:0]        share_q, share_d;
    logic              owned_any_q, owned_any_d;

    logic [3:0] elig;
    logic [3:0] pick_set;
    logic [3:0] pick_onehot;
    logic [1:0] pick_idx;
    logic [3:0] owned_masked;
    logic [1:0] share_cnt;

    // Eligible requesters; the high-priority subset overrides when non-empty.
    always_comb begin
        elig = '0;
        for (int i = 0; i < 4; i++) begin
            elig[i] = req[i] && is_valid_cmd(8'(cmd_arr[i]));
        end
        pick_set = ((elig & pri) != 4'd0) ? (elig & pri) : elig;
    end

    rr_pick4 u_pick (
        .req    (pick_set),
        .ptr    (rr_ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    // Count other caches owning the line; grant still marks the winner here.
    always_comb begin
        owned_masked = owned_vec & ~grant_q;
        share_cnt    = '0;
        for (int i = 0; i < 4; i++) begin
            share_cnt = share_cnt + {1'b0, owned_masked[i]};
        end
    end

    // Next-state and registered-output computation for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        win_idx_d   = win_idx_q;
        cnt_d       = cnt_q;
        sp_out_d    = sp_out_q;
        addr_d      = addr_q;
        sp_valid_d  = 1'b0;
        grant_d     = grant_q;
        done_d      = '0;
        share_d     = share_q;
        owned_any_d = owned_any_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_set != 4'd0) begin
                    win_idx_d  = pick_idx;
                    sp_out_d   = cmd_arr[pick_idx];
                    addr_d     = addr_arr[pick_idx];
                    sp_valid_d = 1'b1;
                    grant_d    = pick_onehot;
                    state_d    = ST_BCAST;
                end
            end
            ST_BCAST: begin
                sp_out_d = '0;
                cnt_d    = '0;
                state_d  = (SNOOP_LAT == 1) ? ST_COLLECT : ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = ST_COLLECT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_COLLECT: begin
                share_d     = share_cnt;
                owned_any_d = (share_cnt != 2'd0);
                done_d      = grant_q;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                rr_ptr_d = win_idx_q + 2'd1;
                grant_d  = '0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops everything back to idle at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            win_idx_q   <= '0;
            cnt_q       <= '0;
            sp_out_q    <= '0;
            addr_q      <= '0;
            sp_valid_q  <= 1'b0;
            grant_q     <= '0;
            done_q      <= '0;
            share_q     <= '0;
            owned_any_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            win_idx_q   <= win_idx_d;
            cnt_q       <= cnt_d;
            sp_out_q    <= sp_out_d;
            addr_q      <= addr_d;
            sp_valid_q  <= sp_valid_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            share_q     <= share_d;
            owned_any_q <= owned_any_d;
        end
    end

    assign sp_out      = sp_out_q;
    assign addr_sp_out = addr_q;
    assign sp_valid    = sp_valid_q;
    assign grant       = grant_q;
    assign done        = done_q;
    assign share_num   = share_q;
    assign owned_any   = owned_any_q;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// tb/tb_snoop_bus_arbiter.sv - self-checking bench for snoop_bus_arbiter
module tb_snoop_bus_arbiter;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  pri;
    logic [2:0]  cmd_in  [4];
    logic [23:0] addr_in [4];
    logic [3:0]  owned;
    logic [2:0]  sp_out;
    logic [23:0] addr_sp_out;
    logic        sp_valid;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic [1:0]  share_num;
    logic        owned_any;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    snoop_bus_arbiter #(.ADDR_W(24), .CMD_W(3), .SNOOP_LAT(L)) dut (
        .clk(clk), .rst(rst), .req(req), .pri(pri),
        .sp_in_0(cmd_in[0]), .sp_in_1(cmd_in[1]), .sp_in_2(cmd_in[2]), .sp_in_3(cmd_in[3]),
        .addr_sp_0(addr_in[0]), .addr_sp_1(addr_in[1]), .addr_sp_2(addr_in[2]), .addr_sp_3(addr_in[3]),
        .owned_0(owned[0]), .owned_1(owned[1]), .owned_2(owned[2]), .owned_3(owned[3]),
        .sp_out(sp_out), .addr_sp_out(addr_sp_out), .sp_valid(sp_valid), .grant(grant),
        .done(done), .share_num(share_num), .owned_any(owned_any)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: ph counts cycles since the arbitration cycle
    // (1 = broadcast, L+1 = owned flags sampled, L+2 = completion).
    int          ph = 0;
    int          m_win = 0;
    int          m_ptr = 0;
    int          m_share = 0;
    logic [2:0]  m_cmd = '0;
    logic [23:0] m_addr = '0;

    always @(posedge clk or posedge rst) begin : model
        int  best;
        bit  any_pri;
        bit  el [4];
        if (rst) begin
            ph = 0; m_ptr = 0; m_share = 0; m_addr = '0; m_win = 0; m_cmd = '0;
        end else if (ph == 0) begin
            any_pri = 0;
            best    = -1;
            for (int i = 0; i < 4; i++) begin
                el[i] = req[i] && (cmd_in[i] >= 3'd1) && (cmd_in[i] <= 3'd4);
                if (el[i] && pri[i]) any_pri = 1;
            end
            for (int k = 0; k < 4; k++) begin
                int j;
                j = (m_ptr + k) % 4;
                if (best < 0 && el[j] && (!any_pri || pri[j])) best = j;
            end
            if (best >= 0) begin
                m_win  = best;
                m_cmd  = cmd_in[best];
                m_addr = addr_in[best];
                ph     = 1;
            end
        end else begin
            if (ph == L + 1) begin
                m_share = 0;
                for (int i = 0; i < 4; i++) if (i != m_win && owned[i]) m_share++;
            end
            if (ph == L + 2) begin
                m_ptr = (m_win + 1) % 4;
                ph    = 0;
            end else begin
                ph++;
            end
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin : compare
        logic [3:0] oh;
        oh = 4'(1 << m_win);
        chk("m_sp_valid", 32'(sp_valid), 32'(ph == 1));
        chk("m_sp_out", 32'(sp_out), (ph == 1) ? 32'(m_cmd) : 32'd0);
        chk("m_addr", 32'(addr_sp_out), 32'(m_addr));
        chk("m_grant", 32'(grant), (ph >= 1 && ph <= L + 2) ? 32'(oh) : 32'd0);
        chk("m_done", 32'(done), (ph == L + 2) ? 32'(oh) : 32'd0);
        chk("m_share", 32'(share_num), 32'(m_share));
        chk("m_owned_any", 32'(owned_any), 32'(m_share != 0));
    end

    // Wait for a done pulse; the finishing requester drops its req right away.
    task automatic wait_done(input int budget, output int idx, output int ncyc);
        idx  = -1;
        ncyc = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done != 4'd0) begin
                for (int i = 0; i < 4; i++) if (done[i]) idx = i;
                ncyc = c + 1;
                req[idx] = 1'b0;
                break;
            end
        end
        checks++;
        if (idx < 0) begin
            errors++;
            $display("FAIL wait_done timeout actual=none expected=done within %0d cycles", budget);
        end
    endtask

    int idx, ncyc;
    int exp_rr [4];
    int exp_pr [4];

    initial begin
        exp_rr = '{0, 1, 2, 3};
        exp_pr = '{2, 3, 0, 1};
        rst = 1'b1; req = '0; pri = '0; owned = '0;
        for (int i = 0; i < 4; i++) begin cmd_in[i] = '0; addr_in[i] = '0; end

        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_sp_out", 32'(sp_out), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single request from cache 0
        cmd_in[0] = 3'b001; addr_in[0] = 24'h110000; owned = 4'b0101; req = 4'b0001;
        @(negedge clk);
        chk("t2_sp_out", 32'(sp_out), 32'h1);
        chk("t2_addr", 32'(addr_sp_out), 32'h110000);
        chk("t2_sp_valid", 32'(sp_valid), 32'h1);
        chk("t2_grant", 32'(grant), 32'h1);
        wait_done(20, idx, ncyc);
        chk("t2_latency", 32'(ncyc), 32'(L + 1));
        chk("t2_done", 32'(done), 32'h1);
        chk("t2_share", 32'(share_num), 32'h1);
        chk("t2_owned_any", 32'(owned_any), 32'h1);
        @(negedge clk);
        chk("t2_idle_grant", 32'(grant), 32'h0);

        // Reset in the middle of a transaction
        cmd_in[2] = 3'b011; addr_in[2] = 24'hABCDEF; req = 4'b0100;
        @(negedge clk);
        chk("t1_grant", 32'(grant), 32'h4);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t1_grant0", 32'(grant), 32'h0);
        chk("t1_addr0", 32'(addr_sp_out), 32'h0);
        chk("t1_share0", 32'(share_num), 32'h0);
        chk("t1_any0", 32'(owned_any), 32'h0);
        chk("t1_done0", 32'(done), 32'h0);
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("t1_no_done", 32'(done), 32'h0);
        end

        // Round robin across all four caches
        cmd_in[0] = 3'b001; cmd_in[1] = 3'b010; cmd_in[2] = 3'b011; cmd_in[3] = 3'b100;
        addr_in[0] = 24'h000100; addr_in[1] = 24'h000200; addr_in[2] = 24'h000300; addr_in[3] = 24'h000400;
        owned = 4'b0110; pri = 4'b0000; req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_done(40, idx, ncyc);
            chk("t3_order", 32'(idx), 32'(exp_rr[k]));
        end
        req[0] = 1'b1;
        wait_done(40, idx, ncyc);
        chk("t3_rerequest", 32'(idx), 32'd0);

        // High priority first, then round robin from the updated pointer
        owned = 4'b1001; pri = 4'b0100; req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_done(40, idx, ncyc);
            chk("t4_order", 32'(idx), 32'(exp_pr[k]));
        end
        pri = '0;

        // NOP and reserved commands never get the bus
        cmd_in[1] = 3'b000; req = 4'b0010;
        repeat (6) begin
            @(negedge clk);
            chk("t5_nop_grant", 32'(grant), 32'h0);
            chk("t5_nop_sp_out", 32'(sp_out), 32'h0);
        end
        cmd_in[1] = 3'b110;
        repeat (6) begin
            @(negedge clk);
            chk("t5_rsv_grant", 32'(grant), 32'h0);
        end
        req = '0;
        @(negedge clk);

        // Winner drops req mid-transaction; every other cache owns the line
        cmd_in[3] = 3'b010; addr_in[3] = 24'h3C3C3C; owned = 4'b1111; req = 4'b1000;
        @(negedge clk);
        chk("t6_grant", 32'(grant), 32'h8);
        req[3] = 1'b0;
        wait_done(20, idx, ncyc);
        chk("t6_done_idx", 32'(idx), 32'd3);
        chk("t6_share", 32'(share_num), 32'h3);
        chk("t6_owned_any", 32'(owned_any), 32'h1);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
